// File: rtl/modport_fifo.sv
// Single-clock FIFO with occupancy-counter status flags.
// Pointers wrap by explicit compare, so any DEPTH >= 2 is supported.
module modport_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int UPP_TH = 4,
    parameter int LOW_TH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam int AF_LVL = DEPTH - UPP_TH;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;

    logic              wr_acc_s;
    logic              rd_acc_s;
    logic [PW-1:0]     wr_ptr_nxt_s;
    logic [PW-1:0]     rd_ptr_nxt_s;
    logic [CW-1:0]     count_nxt_s;
    logic              full_nxt_s;
    logic              empty_nxt_s;
    logic              alm_full_nxt_s;
    logic              alm_empty_nxt_s;

    // Accept decisions, next pointers/count, and flag decode of the next count
    always_comb begin
        wr_acc_s        = i_wren && !o_full;
        rd_acc_s        = i_rden && !o_empty;
        wr_ptr_nxt_s    = wr_ptr_r;
        rd_ptr_nxt_s    = rd_ptr_r;
        count_nxt_s     = count_r;
        full_nxt_s      = 1'b0;
        empty_nxt_s     = 1'b1;
        alm_full_nxt_s  = 1'b0;
        alm_empty_nxt_s = 1'b1;

        if (wr_acc_s) begin
            if (wr_ptr_r == PTR_LAST) begin
                wr_ptr_nxt_s = {PW{1'b0}};
            end else begin
                wr_ptr_nxt_s = wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (rd_acc_s) begin
            if (rd_ptr_r == PTR_LAST) begin
                rd_ptr_nxt_s = {PW{1'b0}};
            end else begin
                rd_ptr_nxt_s = rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_nxt_s = count_r;
        endcase

        // Registering the decode of the next count keeps flags aligned with count
        full_nxt_s      = (count_nxt_s == CNT_FULL);
        empty_nxt_s     = (count_nxt_s == {CW{1'b0}});
        alm_full_nxt_s  = (int'(count_nxt_s) >= AF_LVL);
        alm_empty_nxt_s = (int'(count_nxt_s) <= LOW_TH);
    end

    // Storage array; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem[wr_ptr_r] <= i_wrdata;
        end
    end

    // Pointers, count, read data and status flags
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            o_rddata    <= {DATA_W{1'b0}};
            o_full      <= 1'b0;
            o_empty     <= 1'b1;
            o_alm_full  <= 1'b0;
            o_alm_empty <= 1'b1;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            o_full      <= full_nxt_s;
            o_empty     <= empty_nxt_s;
            o_alm_full  <= alm_full_nxt_s;
            o_alm_empty <= alm_empty_nxt_s;
            if (rd_acc_s) begin
                o_rddata <= mem[rd_ptr_r];
            end else begin
                o_rddata <= o_rddata;
            end
        end
    end

endmodule

// File: tb/tb_modport_fifo.sv
// Self-checking bench: a default-size FIFO and a DEPTH=5 FIFO, both checked
// every cycle against queue-based reference models, plus a hand-computed vector table.
module tb_modport_fifo;

    localparam int BW = 128, BD = 1024, BU = 4, BL = 2;
    localparam int SW = 8,   SD = 5,    SU = 1, SL = 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    logic          b_wren, b_rden, b_full, b_empty, b_af, b_ae;
    logic [BW-1:0] b_wrdata, b_rddata;
    logic          s_wren, s_rden, s_full, s_empty, s_af, s_ae;
    logic [SW-1:0] s_wrdata, s_rddata;

    always #5 clk = ~clk;

    modport_fifo #(.DATA_W(BW), .DEPTH(BD), .UPP_TH(BU), .LOW_TH(BL)) dut_big (
        .clk(clk), .rstn(rstn), .i_wren(b_wren), .i_wrdata(b_wrdata), .i_rden(b_rden),
        .o_rddata(b_rddata), .o_full(b_full), .o_empty(b_empty),
        .o_alm_full(b_af), .o_alm_empty(b_ae));

    modport_fifo #(.DATA_W(SW), .DEPTH(SD), .UPP_TH(SU), .LOW_TH(SL)) dut_small (
        .clk(clk), .rstn(rstn), .i_wren(s_wren), .i_wrdata(s_wrdata), .i_rden(s_rden),
        .o_rddata(s_rddata), .o_full(s_full), .o_empty(s_empty),
        .o_alm_full(s_af), .o_alm_empty(s_ae));

    // Reference models: contents as queues, last popped word as expected read data
    logic [BW-1:0] bq[$];
    logic [SW-1:0] sq[$];
    logic [BW-1:0] b_exp;
    logic [SW-1:0] s_exp;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [SW-1:0] d;
        logic [SW-1:0] rdx;
        logic          e;
        logic          f;
        logic          af;
        logic          ae;
    } vec_t;
    vec_t tv[15];

    task automatic model_step();
        bit bw, br, sw, sr;
        bw = b_wren && (bq.size() != BD);
        br = b_rden && (bq.size() != 0);
        sw = s_wren && (sq.size() != SD);
        sr = s_rden && (sq.size() != 0);
        if (br) b_exp = bq.pop_front();
        if (bw) bq.push_back(b_wrdata);
        if (sr) s_exp = sq.pop_front();
        if (sw) sq.push_back(s_wrdata);
    endtask

    task automatic check_big(input string tag);
        int sz;
        logic e, f, af, ae;
        sz = bq.size();
        e  = (sz == 0);
        f  = (sz == BD);
        af = (sz >= BD - BU);
        ae = (sz <= BL);
        n_vec++;
        if (b_rddata !== b_exp || b_empty !== e || b_full !== f || b_af !== af || b_ae !== ae) begin
            n_err++;
            $display("FAIL %s big: rddata=%h e=%b f=%b af=%b ae=%b, expected rddata=%h e=%b f=%b af=%b ae=%b",
                     tag, b_rddata, b_empty, b_full, b_af, b_ae, b_exp, e, f, af, ae);
        end
    endtask

    task automatic check_small(input string tag);
        int sz;
        logic e, f, af, ae;
        sz = sq.size();
        e  = (sz == 0);
        f  = (sz == SD);
        af = (sz >= SD - SU);
        ae = (sz <= SL);
        n_vec++;
        if (s_rddata !== s_exp || s_empty !== e || s_full !== f || s_af !== af || s_ae !== ae) begin
            n_err++;
            $display("FAIL %s small: rddata=%h e=%b f=%b af=%b ae=%b, expected rddata=%h e=%b f=%b af=%b ae=%b",
                     tag, s_rddata, s_empty, s_full, s_af, s_ae, s_exp, e, f, af, ae);
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_big(tag);
        check_small(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulse_reset(input string tag);
        #2;
        rstn = 1'b1;
        #1;
        bq.delete();
        sq.delete();
        b_exp = '0;
        s_exp = '0;
        check_big(tag);
        check_small(tag);
        #1;
        rstn = 1'b0;
    endtask

    task automatic idle();
        b_wren = 1'b0; b_rden = 1'b0; b_wrdata = '0;
        s_wren = 1'b0; s_rden = 1'b0; s_wrdata = '0;
    endtask

    initial begin
        //          wr    rd    data    exp rd  e     f     af    ae
        tv[0]  = '{1'b1, 1'b0, 8'hA1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[1]  = '{1'b1, 1'b0, 8'hA2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 1'b1, 8'hA3, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 1'b0, 8'hA4, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 8'hA5, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 8'hA6, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 8'hA7, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 1'b1, 8'hA8, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 8'h00, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 8'h00, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[10] = '{1'b0, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[11] = '{1'b0, 1'b1, 8'h00, 8'hA6, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[12] = '{1'b0, 1'b1, 8'h00, 8'hA6, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[13] = '{1'b1, 1'b1, 8'hB1, 8'hA6, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[14] = '{1'b0, 1'b1, 8'h00, 8'hB1, 1'b1, 1'b0, 1'b0, 1'b1};

        idle();
        b_exp = '0;
        s_exp = '0;

        #2;
        rstn = 1'b1;
        #1;
        check_big("reset_initial");
        check_small("reset_initial");
        #1;
        rstn = 1'b0;

        // Hand-computed table on the DEPTH=5 instance: wrap, overflow, underflow, both-extremes
        for (int i = 0; i < 15; i++) begin
            s_wren = tv[i].wr; s_rden = tv[i].rd; s_wrdata = tv[i].d;
            tick("table_model");
            n_vec++;
            if (s_rddata !== tv[i].rdx || s_empty !== tv[i].e || s_full !== tv[i].f ||
                s_af !== tv[i].af || s_ae !== tv[i].ae) begin
                n_err++;
                $display("FAIL table[%0d]: rddata=%h e=%b f=%b af=%b ae=%b, expected rddata=%h e=%b f=%b af=%b ae=%b",
                         i, s_rddata, s_empty, s_full, s_af, s_ae, tv[i].rdx, tv[i].e, tv[i].f, tv[i].af, tv[i].ae);
            end
        end
        idle();

        // Fill the large FIFO with 0..1023, then attempt overflow with 0xAA..
        for (int i = 0; i < BD; i++) begin
            b_wren = 1'b1; b_wrdata = BW'(i);
            tick("fill");
        end
        b_wrdata = {16{8'hAA}};
        for (int i = 0; i < 4; i++) tick("overflow");
        b_wren = 1'b0;

        for (int i = 0; i < BD; i++) begin
            b_rden = 1'b1;
            tick("drain");
        end
        for (int i = 0; i < 3; i++) tick("underflow");
        b_rden = 1'b0;

        // Simultaneous read/write held at a mid-level occupancy of 10
        for (int i = 0; i < 10; i++) begin
            b_wren = 1'b1; b_wrdata = {$urandom, $urandom, $urandom, $urandom};
            tick("mid_fill");
        end
        for (int i = 0; i < 50; i++) begin
            b_wren = 1'b1; b_rden = 1'b1; b_wrdata = {$urandom, $urandom, $urandom, $urandom};
            tick("mid_rw");
        end
        b_wren = 1'b0;
        for (int i = 0; i < 10; i++) tick("mid_drain");
        b_rden = 1'b0;
        tick("mid_idle");

        // Simultaneous read/write at full and at empty
        for (int i = 0; i < BD; i++) begin
            b_wren = 1'b1; b_wrdata = BW'(i + 5000);
            tick("refill");
        end
        b_rden = 1'b1; b_wrdata = {16{8'h55}};
        tick("rw_full");
        b_wren = 1'b0;
        for (int i = 0; i < BD; i++) tick("redrain");
        b_wren = 1'b1; b_wrdata = BW'(32'h1234);
        tick("rw_empty");
        b_wren = 1'b0;
        tick("rw_empty_read");
        idle();

        // Randomised traffic on both instances at several write/read balances
        for (int p = 0; p < 4; p++) begin
            int wp;
            wp = (p == 0) ? 70 : (p == 1) ? 50 : (p == 2) ? 30 : 55;
            for (int i = 0; i < 600; i++) begin
                b_wren = ($urandom_range(0, 99) < wp);
                b_rden = ($urandom_range(0, 99) < (100 - wp));
                b_wrdata = {$urandom, $urandom, $urandom, $urandom};
                s_wren = ($urandom_range(0, 99) < wp);
                s_rden = ($urandom_range(0, 99) < (100 - wp));
                s_wrdata = SW'($urandom);
                tick("random");
            end
        end

        // Reset in the middle of traffic discards all contents
        pulse_reset("reset_midop");
        for (int i = 0; i < 60; i++) begin
            b_wren = ($urandom_range(0, 99) < 60);
            b_rden = ($urandom_range(0, 99) < 40);
            b_wrdata = {$urandom, $urandom, $urandom, $urandom};
            s_wren = ($urandom_range(0, 99) < 60);
            s_rden = ($urandom_range(0, 99) < 40);
            s_wrdata = SW'($urandom);
            tick("post_reset");
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
